// File: rtl/directive_emitter.sv
// directive_emitter: serializes one compiler-directive command per line as ASCII bytes, tracking `ifdef nesting.
// Latency: first byte valid the cycle after acceptance; an N-byte line takes N cycles, next command one cycle later.
// Backpressure: bytes advance only on out_valid && out_ready; cmd_ready stays low for the whole line.
module directive_emitter #(
  parameter int NAME_MAX  = 16,
  parameter int DEPTH_MAX = 8,
  parameter int INDENT    = 4,
  localparam int LW = $clog2(NAME_MAX + 1),
  localparam int DW = $clog2(DEPTH_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [8*NAME_MAX-1:0] cmd_name,
  input  logic [LW-1:0]         cmd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  err,
  output logic [DW-1:0]         depth
);

  // The shared index counter must span the widest indent, name or keyword.
  localparam int IND_MAX = INDENT * DEPTH_MAX;
  localparam int BIG     = (IND_MAX > NAME_MAX) ? IND_MAX : NAME_MAX;
  localparam int CNT_MAX = (BIG > 8) ? BIG : 8;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INDENT, ST_TICK, ST_KEYWORD, ST_SPACE,
    ST_QOPEN, ST_NAME, ST_QCLOSE, ST_NEWLINE
  } state_t;

  // Command as latched at acceptance, with its precomputed indent level.
  typedef struct packed {
    logic [2:0]            op;
    logic [LW-1:0]         len;
    logic [8*NAME_MAX-1:0] name;
    logic [DW-1:0]         lvl;
  } cmd_t;

  state_t                state, state_nxt;
  cmd_t                  cmd_q;
  logic [CW-1:0]         cnt;
  logic                  cnt_inc;
  logic [DEPTH_MAX:0]    else_seen;
  logic                  accept;
  logic                  legal;
  logic [DW-1:0]         lvl_new;
  logic [8*NAME_MAX-1:0] name_sh;

  // Keyword ROM: character idx of the keyword for op, first char in the top byte.
  function automatic logic [7:0] kw_char(input logic [2:0] op, input logic [2:0] idx);
    logic [55:0] s;
    case (op)
      3'd0:    s = "include";
      3'd1:    s = {"define", 8'h00};
      3'd2:    s = {"undef", 16'h0000};
      3'd3:    s = {"ifdef", 16'h0000};
      3'd4:    s = {"ifndef", 8'h00};
      3'd5:    s = {"elsif", 16'h0000};
      3'd6:    s = {"else", 24'h000000};
      default: s = {"endif", 16'h0000};
    endcase
    s = s << (8 * idx);
    return s[55:48];
  endfunction

  function automatic logic [2:0] kw_len(input logic [2:0] op);
    case (op)
      3'd0:    return 3'd7;
      3'd1:    return 3'd6;
      3'd4:    return 3'd6;
      3'd6:    return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign out_valid = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Legality of the offered command against the current nesting state, and its indent level.
  always_comb begin
    legal = 1'b1;
    if (cmd_op[3])
      legal = 1'b0;
    if (cmd_op <= 4'd5 && (cmd_len == '0 || int'(cmd_len) > NAME_MAX))
      legal = 1'b0;
    if (cmd_op >= 4'd5 && cmd_op <= 4'd7 && depth == '0)
      legal = 1'b0;
    if ((cmd_op == 4'd5 || cmd_op == 4'd6) && else_seen[depth])
      legal = 1'b0;
    if ((cmd_op == 4'd3 || cmd_op == 4'd4) && int'(depth) == DEPTH_MAX)
      legal = 1'b0;
    lvl_new = (cmd_op >= 4'd5) ? depth - DW'(1) : depth;
  end

  // Next state and the byte currently presented on the stream.
  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    name_sh   = cmd_q.name >> (8 * cnt);
    case (state)
      ST_IDLE: begin
        if (accept && legal)
          state_nxt = (lvl_new != '0) ? ST_INDENT : ST_TICK;
      end
      ST_INDENT: begin
        out_data = 8'h20;
        if (out_ready) begin
          if (int'(cnt) == INDENT * int'(cmd_q.lvl) - 1) state_nxt = ST_TICK;
          else                                           cnt_inc   = 1'b1;
        end
      end
      ST_TICK: begin
        out_data = 8'h60;
        if (out_ready) state_nxt = ST_KEYWORD;
      end
      ST_KEYWORD: begin
        out_data = kw_char(cmd_q.op, cnt[2:0]);
        if (out_ready) begin
          if (int'(cnt) == int'(kw_len(cmd_q.op)) - 1)
            state_nxt = (cmd_q.op <= 3'd5) ? ST_SPACE : ST_NEWLINE;
          else
            cnt_inc = 1'b1;
        end
      end
      ST_SPACE: begin
        out_data = 8'h20;
        if (out_ready) state_nxt = (cmd_q.op == 3'd0) ? ST_QOPEN : ST_NAME;
      end
      ST_QOPEN: begin
        out_data = 8'h22;
        if (out_ready) state_nxt = ST_NAME;
      end
      ST_NAME: begin
        out_data = name_sh[7:0];
        if (out_ready) begin
          if (int'(cnt) == int'(cmd_q.len) - 1)
            state_nxt = (cmd_q.op == 3'd0) ? ST_QCLOSE : ST_NEWLINE;
          else
            cnt_inc = 1'b1;
        end
      end
      ST_QCLOSE: begin
        out_data = 8'h22;
        if (out_ready) state_nxt = ST_NEWLINE;
      end
      ST_NEWLINE: begin
        out_data = 8'h0A;
        out_last = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; the index counter restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt_inc)       cnt <= cnt + CW'(1);
    end
  end

  // Command latch, nesting bookkeeping and the one-cycle reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      depth     <= '0;
      else_seen <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        cmd_q <= '{op: cmd_op[2:0], len: cmd_len, name: cmd_name, lvl: lvl_new};
        case (cmd_op)
          4'd3, 4'd4: begin
            depth                      <= depth + DW'(1);
            else_seen[depth + DW'(1)]  <= 1'b0;
          end
          4'd6:    else_seen[depth] <= 1'b1;
          4'd7:    depth <= depth - DW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_directive_emitter.sv
// tb_directive_emitter: directed and random directive commands checked against a queue-based reference model.
// Latency: expects first byte the cycle after acceptance and cmd_ready back the cycle after the newline.
// Backpressure: out_ready is either held high or toggled at random per cycle.
module tb_directive_emitter;
  localparam int NAME_MAX  = 16;
  localparam int DEPTH_MAX = 8;
  localparam int INDENT    = 4;
  localparam int LW = $clog2(NAME_MAX + 1);
  localparam int DW = $clog2(DEPTH_MAX + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [3:0]            cmd_op = '0;
  logic [8*NAME_MAX-1:0] cmd_name = '0;
  logic [LW-1:0]         cmd_len = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [7:0]            out_data;
  logic                  out_last;
  logic                  err;
  logic [DW-1:0]         depth;

  int compared = 0;
  int mismatched = 0;

  // Nesting model: one entry per open conditional, value = else already seen.
  bit         es_stack[$];
  logic [7:0] exp_q[$];
  string      kw_tab[8] = '{"include", "define", "undef", "ifdef", "ifndef", "elsif", "else", "endif"};

  directive_emitter #(.NAME_MAX(NAME_MAX), .DEPTH_MAX(DEPTH_MAX), .INDENT(INDENT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_name(cmd_name), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8*NAME_MAX-1:0] pack(input string s);
    logic [8*NAME_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < NAME_MAX; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic bit model_legal(input int op, input int len);
    int d;
    d = es_stack.size();
    if (op > 7) return 1'b0;
    if (op <= 5 && (len == 0 || len > NAME_MAX)) return 1'b0;
    if (op >= 5 && d == 0) return 1'b0;
    if ((op == 5 || op == 6) && es_stack[d-1]) return 1'b0;
    if ((op == 3 || op == 4) && d == DEPTH_MAX) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void build_line(input int op, input logic [8*NAME_MAX-1:0] nm, input int len);
    int    lvl;
    string k;
    lvl = (op >= 5) ? es_stack.size() - 1 : es_stack.size();
    k = kw_tab[op];
    exp_q.delete();
    repeat (INDENT * lvl) exp_q.push_back(8'h20);
    exp_q.push_back(8'h60);
    for (int j = 0; j < k.len(); j++) exp_q.push_back(k[j]);
    if (op <= 5) begin
      exp_q.push_back(8'h20);
      if (op == 0) exp_q.push_back(8'h22);
      for (int j = 0; j < len; j++) exp_q.push_back(nm[8*j +: 8]);
      if (op == 0) exp_q.push_back(8'h22);
    end
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void model_update(input int op);
    if (op == 3 || op == 4) es_stack.push_back(1'b0);
    else if (op == 6)       es_stack[es_stack.size()-1] = 1'b1;
    else if (op == 7)       void'(es_stack.pop_back());
  endfunction

  task automatic run_cmd(input int op, input logic [8*NAME_MAX-1:0] nm, input int len, input bit stall);
    bit         legal, done, bad_valid, bad_busy, bad_hold, bad_last, stalled;
    int         cycles;
    logic [7:0] held;
    logic [7:0] got[$];
    legal = model_legal(op, len);
    if (legal) begin
      build_line(op, nm, len);
      model_update(op);
    end
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 4'(op);
    cmd_name  = nm;
    cmd_len   = LW'(len);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("err_op%0d", op), err, 32'(!legal));
    chk($sformatf("depth_op%0d", op), depth, es_stack.size());
    chk($sformatf("first_valid_op%0d", op), out_valid, 32'(legal));
    if (!legal) begin
      @(negedge clk);
      chk("err_one_cycle", err, 0);
      chk("idle_after_err", out_valid, 0);
      return;
    end
    cycles = 0; done = 0; bad_valid = 0; bad_busy = 0; bad_hold = 0; bad_last = 0;
    stalled = 0; held = '0;
    while (!done && cycles < 500) begin
      if (out_valid !== 1'b1) bad_valid = 1;
      if (cmd_ready !== 1'b0) bad_busy = 1;
      if (stalled && out_data !== held) bad_hold = 1;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        got.push_back(out_data);
        if (out_last !== ((got.size() == exp_q.size()) ? 1'b1 : 1'b0)) bad_last = 1;
        if (out_last === 1'b1) done = 1;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = out_data;
      cycles++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("line_terminated", 32'(done), 1);
    chk("line_length", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("byte%0d_op%0d", i, op), (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
    chk("valid_steady", 32'(bad_valid), 0);
    chk("busy_during_line", 32'(bad_busy), 0);
    chk("hold_while_stalled", 32'(bad_hold), 0);
    chk("last_only_on_newline", 32'(bad_last), 0);
    chk("ready_after_line", cmd_ready, 1);
    chk("valid_after_line", out_valid, 0);
    if (!stall) chk("line_cycles", cycles, exp_q.size());
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_depth", depth, 0);

    // Basic lines and nesting
    run_cmd(3, pack("FOO"), 3, 0);
    run_cmd(7, '0, 0, 0);
    run_cmd(3, pack("A"), 1, 0);
    run_cmd(3, pack("B"), 1, 0);
    run_cmd(6, '0, 0, 0);
    run_cmd(7, '0, 0, 0);
    run_cmd(7, '0, 0, 0);
    run_cmd(0, pack("a.vh"), 4, 0);

    // Rejections
    run_cmd(7, '0, 0, 0);
    run_cmd(3, pack("A"), 1, 0);
    run_cmd(6, '0, 0, 0);
    run_cmd(6, '0, 0, 0);
    run_cmd(5, pack("Z"), 1, 0);
    run_cmd(7, '0, 0, 0);
    run_cmd(9, pack("Q"), 1, 0);
    run_cmd(1, pack("D"), 0, 0);
    run_cmd(1, pack("LONG"), 17, 0);
    run_cmd(1, pack("ABCDEFGHIJKLMNOP"), 16, 0);
    repeat (9) run_cmd(3, pack("N"), 1, 0);
    run_cmd(4, pack("M"), 1, 0);
    repeat (8) run_cmd(7, '0, 0, 0);

    // Backpressure
    repeat (4) run_cmd(1, pack("X"), 1, 1);

    // Reset in the middle of a line
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_name = pack("FOO"); cmd_len = LW'(3); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_depth", depth, 0);
    chk("async_rst_last", out_last, 0);
    chk("async_rst_ready", cmd_ready, 1);
    es_stack.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    run_cmd(7, '0, 0, 0);

    // Random commands against the model
    repeat (60) begin
      int op;
      int len;
      logic [8*NAME_MAX-1:0] nm;
      op = $urandom_range(0, 9);
      if (op > 7) op = $urandom_range(8, 15);
      len = ($urandom_range(0, 9) == 0) ? 17 * $urandom_range(0, 1) : $urandom_range(1, NAME_MAX);
      nm = '0;
      for (int i = 0; i < NAME_MAX; i++) nm[8*i +: 8] = 8'($urandom_range(97, 122));
      run_cmd(op, nm, len, 1'($urandom_range(0, 1)));
    end
    while (es_stack.size() > 0) run_cmd(7, '0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/directive_emitter.md
# directive_emitter

Hardware writer for SystemVerilog compiler-directive text. It accepts one directive command at a time (`include, `define, `undef, `ifdef, `ifndef, `elsif, `else, `endif) and serializes it as an ASCII line on a byte stream. It tracks conditional nesting so that it indents each line and rejects malformed sequences. It sits upstream of the source-generation path and is the producing end of the stream that the directive parser consumes.

## Interface
Parameters:
- NAME_MAX, 16: maximum name length in bytes.
- DEPTH_MAX, 8: maximum `ifdef/`ifndef nesting depth.
- INDENT, 4: spaces emitted per nesting level.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  4  0 include, 1 define, 2 undef, 3 ifdef, 4 ifndef, 5 elsif, 6 else, 7 endif; 8-15 illegal.
- cmd_name  in  8*NAME_MAX  name bytes; byte 0 is in bits [7:0] and is emitted first.
- cmd_len  in  $clog2(NAME_MAX+1)  number of valid name bytes.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  ASCII byte.
- out_last  out  1  marks the final byte of a line (0x0A).
- err  out  1  one-cycle pulse when a command is rejected.
- depth  out  $clog2(DEPTH_MAX+1)  current nesting depth.

## Operation
- The command is latched on the handshake. cmd_ready = (state == IDLE).
- Line format, in order:
  - indent of INDENT*L spaces (0x20);
  - 0x60 (backtick);
  - the keyword;
  - for ops 0-5: 0x20, then the name (for op 0, the name is wrapped in 0x22 quotes);
  - 0x0A with out_last=1.
- Indent level L:
  - ops 0-4: L = depth;
  - ops 5-7: L = depth-1.
- Depth update, applied at acceptance:
  - ops 3 and 4: depth+1, and else_seen[new level]=0;
  - op 6: else_seen[depth]=1;
  - op 7: depth-1.
- Rejection rules (err pulse, no bytes emitted, depth and else_seen unchanged, command consumed):
  - op 8-15;
  - ops 0-5 with cmd_len==0 or cmd_len>NAME_MAX;
  - ops 5-7 at depth 0;
  - ops 5-6 when else_seen[depth]=1;
  - ops 3-4 at depth==DEPTH_MAX.
- FSM states: IDLE, INDENT, TICK, KEYWORD, SPACE, QOPEN, NAME, QCLOSE, NEWLINE.
- Transitions:
  - IDLE → INDENT on a legal accept with L>0; otherwise IDLE → TICK.
  - INDENT advances on each byte handshake until its counter reaches INDENT*L.
  - TICK → KEYWORD.
  - KEYWORD → SPACE (ops 0-5) or NEWLINE (ops 6-7) after the last keyword char.
  - SPACE → QOPEN (op 0) or NAME.
  - NAME → QCLOSE (op 0) or NEWLINE after cmd_len bytes.
  - QCLOSE → NEWLINE.
  - NEWLINE → IDLE.
- The keyword ROM holds 8 strings of at most 7 chars. The index counter is reused across INDENT, KEYWORD and NAME and is cleared on each state change.

## Timing
- Reset values: state IDLE, cmd_ready 1, out_valid 0, out_data 0x00, out_last 0, err 0, depth 0, else_seen all 0.
- Command accepted at edge T:
  - legal command: out_valid=1 with the first byte from T+1;
  - illegal command: err=1 for exactly cycle T+1 only, state stays IDLE, cmd_ready stays 1.
- Each byte advances only on the edge where out_valid && out_ready. out_data and out_last hold stable while stalled.
- out_valid never drops mid-line.
- Back-to-back throughput: a line of N bytes with out_ready=1 costs N cycles. cmd_ready rises in the cycle after the 0x0A handshake, so one command completes per N+1 cycles.
- The depth output reflects the update from T+1, before the line is emitted.
- Reset asserted mid-line: all outputs take their reset values immediately (asynchronously). The partial line is abandoned with no out_last, and nesting state clears.

## Test plan
- ifdef "FOO" (len 3) at depth 0, out_ready=1:
  - bytes 60 69 66 64 65 66 20 46 4F 4F 0A;
  - out_last only on 0A;
  - depth 0→1;
  - cmd_ready returns after 11 byte cycles.
- ifdef A, ifdef B, else, endif, endif:
  - indents are 0, 4, 4, 4, 0 spaces;
  - the else line is 4×20 60 65 6C 73 65 0A;
  - depth sequence is 1, 2, 2, 1, 0.
- include "a.vh":
  - bytes 60 "include" 20 22 61 2E 76 68 22 0A;
  - depth stays 0.
- Error cases, each producing a one-cycle err pulse, no out_valid, and unchanged depth:
  - endif at depth 0;
  - else following else at the same level;
  - op 9;
  - define with len 0;
  - a ninth nested ifdef when DEPTH_MAX=8.
- Backpressure:
  - toggle out_ready at random 50% for a define "X";
  - out_data holds steady while out_ready=0;
  - the byte sequence exactly matches the unstalled case;
  - cmd_ready stays 0 until 0A is accepted.
- Reset mid-line:
  - drop rst_n after the third byte of an ifdef;
  - out_valid goes 0 asynchronously and depth reads 0;
  - after release, endif is rejected with err.
